// File: rtl/normalizer.sv
// -----------------------------------------------------------------------------
// normalizer
//   Iterative leading-one normalizer, the inverse of the Shifter block. It takes
//   a 32-bit unsigned value and moves it one bit per cycle until its leading one
//   sits at bit TARGET. It returns the mantissa and a signed power such that
//   shifting out_mant by out_power (left if positive, right if negative)
//   reproduces the input, minus any bits discarded by right shifts.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_valid    in_value is valid
//   in_ready    block can accept an input (IDLE only)
//   in_value    unsigned value to normalize
//   out_valid   result valid, held until accepted
//   out_ready   downstream accepts the result
//   out_mant    normalized mantissa, leading one at bit TARGET (0 for zero input)
//   out_power   signed 8-bit shift count
//   out_zero    input was zero
//   out_sticky  OR of every 1 bit discarded by right shifts
// -----------------------------------------------------------------------------
module normalizer #(
  parameter int TARGET = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_mant,
  output logic [7:0]  out_power,
  output logic        out_zero,
  output logic        out_sticky
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Bits strictly above TARGET; computed in 64 bits so TARGET=31 yields an
  // empty mask instead of an out-of-range shift.
  localparam logic [63:0] LOW_MASK = (64'd1 << (TARGET + 1)) - 64'd1;
  localparam logic [31:0] HI_MASK  = ~LOW_MASK[31:0];

  state_t             state_q, state_d;
  logic        [31:0] work_q, work_d;
  logic signed [7:0]  power_q, power_d;
  logic               sticky_q, sticky_d;

  // Result registers hold the last result after the handshake while the
  // working registers are reused by the next transaction.
  logic        [31:0] out_mant_q, out_mant_d;
  logic signed [7:0]  out_power_q, out_power_d;
  logic               out_zero_q, out_zero_d;
  logic               out_sticky_q, out_sticky_d;

  always_comb begin
    state_d      = state_q;
    work_d       = work_q;
    power_d      = power_q;
    sticky_d     = sticky_q;
    out_mant_d   = out_mant_q;
    out_power_d  = out_power_q;
    out_zero_d   = out_zero_q;
    out_sticky_d = out_sticky_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d   = in_value;
          power_d  = 8'sd0;
          sticky_d = 1'b0;
          state_d  = SCAN;
        end
      end

      SCAN: begin
        if (work_q == 32'd0) begin
          state_d      = DONE;
          out_mant_d   = work_q;
          out_power_d  = power_q;
          out_zero_d   = 1'b1;
          out_sticky_d = sticky_q;
        end else if ((work_q & HI_MASK) != 32'd0) begin
          work_d   = work_q >> 1;
          sticky_d = sticky_q | work_q[0];
          power_d  = power_q + 8'sd1;
        end else if (!work_q[TARGET]) begin
          // Nothing above TARGET is set, so the left shift loses no bits.
          work_d  = work_q << 1;
          power_d = power_q - 8'sd1;
        end else begin
          state_d      = DONE;
          out_mant_d   = work_q;
          out_power_d  = power_q;
          out_zero_d   = 1'b0;
          out_sticky_d = sticky_q;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      out_mant_q   <= 32'd0;
      out_power_q  <= 8'sd0;
      out_zero_q   <= 1'b0;
      out_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_mant_q   <= out_mant_d;
      out_power_q  <= out_power_d;
      out_zero_q   <= out_zero_d;
      out_sticky_q <= out_sticky_d;
    end
  end

  // Working datapath, always reloaded on acceptance
  always_ff @(posedge clk) begin
    work_q   <= work_d;
    power_q  <= power_d;
    sticky_q <= sticky_d;
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_mant   = out_mant_q;
  assign out_power  = out_power_q;
  assign out_zero   = out_zero_q;
  assign out_sticky = out_sticky_q;

endmodule

// File: tb/tb_normalizer.sv
module tb_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_mant;
  logic [7:0]  out_power;
  logic        out_zero;
  logic        out_sticky;

  int checks = 0;
  int errors = 0;

  normalizer #(.TARGET(23)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_power (out_power),
    .out_zero  (out_zero),
    .out_sticky(out_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a value and let the accepting edge pass.
  task automatic start(input logic [31:0] val, input string tag);
    check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_value = val;
    tick();
    in_valid = 1'b0;
    in_value = 32'd0;
  endtask

  // Count edges after acceptance until out_valid (bounded), then check result.
  task automatic wait_result(input logic [31:0] exp_mant, input logic [7:0] exp_pow,
                             input logic exp_zero, input logic exp_sticky,
                             input int d, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, n, d + 1);
    check({tag, " mant"},   out_mant, exp_mant);
    check({tag, " power"},  {24'd0, out_power}, {24'd0, exp_pow});
    check({tag, " zero"},   {31'd0, out_zero}, {31'd0, exp_zero});
    check({tag, " sticky"}, {31'd0, out_sticky}, {31'd0, exp_sticky});
  endtask

  task automatic handshake(input logic [31:0] exp_mant, input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, " ready rise"}, {31'd0, in_ready}, 32'd1);
    check({tag, " mant hold"}, out_mant, exp_mant);
  endtask

  task automatic run(input logic [31:0] val, input logic [31:0] exp_mant,
                     input logic [7:0] exp_pow, input logic exp_zero,
                     input logic exp_sticky, input int d, input string tag);
    start(val, tag);
    wait_result(exp_mant, exp_pow, exp_zero, exp_sticky, d, tag);
    handshake(exp_mant, tag);
  endtask

  initial begin
    int n;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_value  = 32'd0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst in_ready",   {31'd0, in_ready},   32'd1);
    check("rst out_valid",  {31'd0, out_valid},  32'd0);
    check("rst out_mant",   out_mant,            32'd0);
    check("rst out_power",  {24'd0, out_power},  32'd0);
    check("rst out_zero",   {31'd0, out_zero},   32'd0);
    check("rst out_sticky", {31'd0, out_sticky}, 32'd0);

    // Directed vectors
    run(32'h0080_0000, 32'h0080_0000, 8'h00, 1'b0, 1'b0, 0,  "norm");
    run(32'h0000_0001, 32'h0080_0000, 8'hE9, 1'b0, 1'b0, 23, "left1");
    run(32'h8000_0001, 32'h0080_0000, 8'h08, 1'b0, 1'b1, 8,  "right_lossy");
    run(32'h0100_0000, 32'h0080_0000, 8'h01, 1'b0, 1'b0, 1,  "right1");
    run(32'h0000_0000, 32'h0000_0000, 8'h00, 1'b1, 1'b0, 0,  "zero");
    run(32'hFFFF_FFFF, 32'h00FF_FFFF, 8'h08, 1'b0, 1'b1, 8,  "allones");
    run(32'h00FF_FFFF, 32'h00FF_FFFF, 8'h00, 1'b0, 1'b0, 0,  "full_mant");
    run(32'h0000_0003, 32'h00C0_0000, 8'hEA, 1'b0, 1'b0, 22, "left3");
    run(32'h0300_0000, 32'h00C0_0000, 8'h02, 1'b0, 1'b0, 2,  "right_exact");

    // Backpressure: hold the result for 5 cycles with a new input pending
    start(32'h0100_0000, "bp");
    wait_result(32'h0080_0000, 8'h01, 1'b0, 1'b0, 1, "bp");
    in_valid = 1'b1;
    in_value = 32'h0000_0100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp valid held", {31'd0, out_valid}, 32'd1);
      check("bp in_ready low", {31'd0, in_ready}, 32'd0);
      check("bp mant stable", out_mant, 32'h0080_0000);
      check("bp power stable", {24'd0, out_power}, 32'h01);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp valid drop", {31'd0, out_valid}, 32'd0);
    check("bp in_ready rise", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_value = 32'd0;
    check("bp held accepted", {31'd0, in_ready}, 32'd0);
    wait_result(32'h0080_0000, 8'hF1, 1'b0, 1'b0, 15, "bp_next");
    handshake(32'h0080_0000, "bp_next");

    // Reset mid-SCAN discards the pending result
    start(32'h0000_0001, "rstscan");
    for (int i = 0; i < 4; i++) tick();
    check("rstscan busy", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstscan in_ready", {31'd0, in_ready}, 32'd1);
    check("rstscan out_valid", {31'd0, out_valid}, 32'd0);
    check("rstscan out_mant", out_mant, 32'd0);
    check("rstscan out_power", {24'd0, out_power}, 32'd0);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) n++;
    end
    check("rstscan no result", n, 0);
    run(32'h0000_0100, 32'h0080_0000, 8'hF1, 1'b0, 1'b0, 15, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
